// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed WIDTH x WIDTH multiply / divide engine.
// Radix-2 Booth multiply and non-restoring divide, one iteration per cycle
// for WIDTH cycles. The 2*WIDTH result is held as {z_hi, z_lo} and feeds
// the bus multiplexer's ZHI/ZLO inputs directly.
// Optional feature macro: MULDIV_DIV_EN (divider, sign fix-up, div_by_zero).
// With the macro undefined, op is ignored and every start is a multiply.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH+1:0] r_hi;     // Booth high half (sign-extended) or partial remainder
    logic [WIDTH-1:0] r_lo;     // Booth low half or quotient / dividend shift register
    logic             r_guard;  // Booth guard bit q[-1]
    logic [WIDTH-1:0] r_opnd;   // multiplicand or |divisor|
    logic             r_done;
    logic [WIDTH-1:0] r_z_hi;
    logic [WIDTH-1:0] r_z_lo;

    logic [WIDTH+1:0] w_mcand_ext;
    logic [WIDTH+1:0] w_booth_sum;
    logic [WIDTH+1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;

    // One Booth step: add/sub/none on the high half, then arithmetic shift right.
    always_comb begin
        w_mcand_ext = {{2{r_opnd[WIDTH-1]}}, r_opnd};
        // NOTE: default assigned before the case so no path leaves it unassigned (no latch).
        w_booth_sum = r_hi;
        case ({r_lo[0], r_guard})
            2'b01:   w_booth_sum = r_hi + w_mcand_ext;
            2'b10:   w_booth_sum = r_hi - w_mcand_ext;
            default: ;
        endcase
        w_mul_hi = {w_booth_sum[WIDTH+1], w_booth_sum[WIDTH+1:1]};
        w_mul_lo = {w_booth_sum[0], r_lo[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic             r_op;
    logic             r_a_neg;
    logic             r_q_neg;
    logic             r_dbz;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH+1:0] w_div_ext;
    logic [WIDTH+1:0] w_rem_shift;
    logic [WIDTH+1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_rem_out;
    logic [WIDTH-1:0] w_quo_out;

    // Non-restoring divide step on magnitudes, plus the final correction and sign fix-up.
    always_comb begin
        w_abs_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
        w_abs_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;
        w_div_ext   = {2'b00, r_opnd};
        w_rem_shift = {r_hi[WIDTH:0], r_lo[WIDTH-1]};
        w_rem_next  = r_hi[WIDTH+1] ? (w_rem_shift + w_div_ext) : (w_rem_shift - w_div_ext);
        w_quo_next  = {r_lo[WIDTH-2:0], ~w_rem_next[WIDTH+1]};
        // A negative final remainder is restored by one add of the divisor.
        w_rem_fix   = r_hi[WIDTH+1] ? (r_hi[WIDTH-1:0] + r_opnd) : r_hi[WIDTH-1:0];
        w_rem_out   = r_a_neg ? -w_rem_fix : w_rem_fix;
        w_quo_out   = r_q_neg ? -r_lo : r_lo;
    end

    assign div_by_zero = r_dbz;
`else
    logic w_unused_op;
    assign w_unused_op = op;
    assign div_by_zero = 1'b0;
`endif

    // Sequencer and datapath registers; z_hi/z_lo change only on the FIX edge.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_guard <= 1'b0;
            r_opnd  <= '0;
            r_done  <= 1'b0;
            r_z_hi  <= '0;
            r_z_lo  <= '0;
`ifdef MULDIV_DIV_EN
            r_op    <= 1'b0;
            r_a_neg <= 1'b0;
            r_q_neg <= 1'b0;
            r_dbz   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_guard <= 1'b0;
                        r_hi    <= '0;
                        r_lo    <= operand_b;
                        r_opnd  <= operand_a;
`ifdef MULDIV_DIV_EN
                        r_op    <= op;
                        r_dbz   <= 1'b0;
                        r_a_neg <= operand_a[WIDTH-1];
                        r_q_neg <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        if (op) begin
                            r_lo   <= w_abs_a;
                            r_opnd <= w_abs_b;
                            if (operand_b == '0) begin
                                // Nothing to iterate; keep the raw dividend for z_hi.
                                r_state <= FIX;
                                r_dbz   <= 1'b1;
                                r_lo    <= operand_a;
                            end
                        end
`endif
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                    r_hi    <= w_mul_hi;
                    r_lo    <= w_mul_lo;
                    r_guard <= r_lo[0];
`ifdef MULDIV_DIV_EN
                    if (r_op) begin
                        r_hi <= w_rem_next;
                        r_lo <= w_quo_next;
                    end
`endif
                end
                FIX: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                    r_z_hi  <= r_hi[WIDTH-1:0];
                    r_z_lo  <= r_lo;
`ifdef MULDIV_DIV_EN
                    if (r_dbz) begin
                        r_z_hi <= r_lo;
                        r_z_lo <= '1;
                    end else if (r_op) begin
                        r_z_hi <= w_rem_out;
                        r_z_lo <= w_quo_out;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign z_hi = r_z_hi;
    assign z_lo = r_z_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
// Divide vectors are exercised when MULDIV_DIV_EN is defined; otherwise the
// op-ignored multiply behaviour is checked instead.
module tb_mul_div_unit;

    logic        clk;
    logic        clear_n;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] z_hi;
    logic [31:0] z_lo;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .z_hi        (z_hi),
        .z_lo        (z_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive one start pulse, then scramble the operands.
    task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(negedge clk);
        start     = 1'b0;
        operand_a = 32'hA5A5_A5A5;
        operand_b = 32'h5A5A_5A5A;
    endtask

    // Wait (bounded) for done, counting cycles after E0 and watching z_hi/z_lo.
    task automatic wait_done(output int lat, output bit held);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0  = z_hi;
        lo0  = z_lo;
        lat  = 0;
        held = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (z_hi !== hi0 || z_lo !== lo0) held = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    // Full operation: optional alignment, launch, then latency/result/hold checks.
    task automatic do_op(input string tag, input bit align, input logic o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_lat);
        int lat;
        bit held;
        if (align) begin
            @(negedge clk);
        end else begin
            check({tag, "_b2b_idle"}, {63'd0, busy}, 64'd0);
        end
        launch(o, a, b);
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        check({tag, "_done_low"}, {63'd0, done}, 64'd0);
        wait_done(lat, held);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_hold"}, {63'd0, held}, 64'd1);
        check({tag, "_res"}, {z_hi, z_lo}, {exp_hi, exp_lo});
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int  lat;
        bit  held;
        bit  seen;
        clear_n   = 1'b0;
        start     = 1'b0;
        op        = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(negedge clk);
        check("rst_state", {z_hi, z_lo}, 64'd0);
        check("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        clear_n = 1'b1;

        // Multiplies
        do_op("mul_7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        do_op("mul_min_sq", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33);
        do_op("mul_shift", 1'b1, 1'b0, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 33);
        do_op("mul_m1xm1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 33);
        do_op("mul_max_sq", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1, 33);

        // Start pulsed during RUN must be ignored
        @(negedge clk);
        launch(1'b0, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        start     = 1'b1;
        op        = 1'b0;
        operand_a = 32'd9;
        operand_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, held);
        check("ign_lat", 64'(lat + 6), 64'd33);
        check("ign_res", {z_hi, z_lo}, 64'd30);

        // Back-to-back: second start issued in the done cycle
        do_op("b2b_first", 1'b1, 1'b0, 32'd7, 32'd6, 32'h0, 32'd42, 33);
        do_op("b2b_second", 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFEE, 33);

`ifdef MULDIV_DIV_EN
        do_op("div_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        do_op("div_100_m7", 1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 33);
        do_op("div_min_m1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        do_op("div_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        do_op("div_min_min", 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'd1, 33);
        do_op("div_by_0", 1'b1, 1'b1, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1);
        check("dbz_set", {63'd0, div_by_zero}, 64'd1);
        do_op("div_20_3", 1'b1, 1'b1, 32'd20, 32'd3, 32'd2, 32'd6, 33);
        check("dbz_clear", {63'd0, div_by_zero}, 64'd0);
`else
        do_op("op_ignored", 1'b1, 1'b1, 32'd6, 32'd4, 32'h0, 32'd24, 33);
        check("dbz_tied", {63'd0, div_by_zero}, 64'd0);
`endif

        // Reset ten cycles into a multiply: abort, clear results, no done afterwards
        @(negedge clk);
        launch(1'b0, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        clear_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_z", {z_hi, z_lo}, 64'd0);
        @(negedge clk);
        clear_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", {63'd0, seen}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
